gmii_rx_checker: RTL and testbench
==================================

# gmii_rx_checker

Receive-side checker on the GMII receive port of a bench node. It consumes `gmii_rxd`/`gmii_rxdv`/`gmii_rxer` from the DUT, strips the preamble and SFD, and checks each frame for CRC-32, length, destination address and the incrementing payload pattern that the transmit side generates. It classifies every frame, keeps saturating per-category counters, and raises `done` once the expected number of good frames has arrived.

## Interface

Parameters:
- `EXPECT_NUM`, default 1: number of good frames after which `done` sets.
- `PAYLOAD_CHECK`, default 1: when 1, payload byte k must equal (k+1) mod 256.
- `PROMISC`, default 0: when 1, the destination-address filter is disabled.
- `MAX_FRAME`, default 1522: maximum frame bytes, destination MAC through FCS.
- `CNT_W`, default 16: width of every counter.

Ports:
- `gmii_rxc`, in, 1: the single clock. All logic is on its rising edge.
- `reset_n`, in, 1: synchronous, active-low reset.
- `gmii_rxd`, in, 8: receive data.
- `gmii_rxdv`, in, 1: receive data valid.
- `gmii_rxer`, in, 1: receive error.
- `mac_addr`, in, 48: own address, sampled every cycle.
- `rx_valid`, out, 1: one-cycle pulse, frame result available.
- `rx_status`, out, 3: result code. 0 GOOD, 1 PRE_ERR, 2 PHY_ERR, 3 RUNT, 4 LONG, 5 CRC_ERR, 6 ADDR_DROP, 7 PAT_ERR.
- `rx_dst_mac`, `rx_src_mac`, out, 48 each: captured header fields.
- `rx_eth_type`, out, 16: captured type/length field.
- `rx_len`, out, 16: frame byte count, destination MAC through FCS.
- `cnt_good`, `cnt_pre_err`, `cnt_phy_err`, `cnt_len_err`, `cnt_crc_err`, `cnt_drop`, `cnt_pat_err`, out, `CNT_W` each: saturating counters.
- `done`, out, 1: sticky; sets when `cnt_good` reaches `EXPECT_NUM`.

## Operation

State machine: IDLE, PRE, FRAME, WAIT_IDLE.

- **IDLE**
  - Goes to PRE only on a `gmii_rxdv` rising edge, i.e. rxdv=1 while the registered rxdv is 0.
  - The registered rxdv resets to 1, so a frame already in progress when reset releases is ignored and counts nothing.
- **PRE**
  - Accepts 0 to 7 bytes of 0x55, then requires 0xD5 (SFD) and goes to FRAME.
  - Any other byte, an 8th 0x55, or rxdv dropping gives PRE_ERR; the machine then goes to WAIT_IDLE if rxdv is still high, otherwise to IDLE.
- **FRAME**, for each byte with rxdv=1:
  - Byte counter increments and saturates at `MAX_FRAME`+1.
  - CRC register updates: reflected polynomial 0xEDB88320, initialised to 0xFFFFFFFF at the SFD.
  - Header capture: bytes 0-5 go to dst, 6-11 to src, 12-13 to type, most significant byte first.
  - A 4-byte delay line separates payload from FCS. A byte leaving the delay line with index ≥14 is payload and is checked against the pattern when `PAYLOAD_CHECK`=1.
  - Any `gmii_rxer`=1 sets a sticky phy flag.
- **End of frame**: rxdv falls while in FRAME.
  - Evaluate the frame and go to IDLE. The status is the first true condition in this priority:
    1. PHY_ERR: phy flag set.
    2. RUNT: len < 64.
    3. LONG: len > `MAX_FRAME`.
    4. CRC_ERR: CRC residue ≠ 0xDEBB20E3.
    5. ADDR_DROP: `PROMISC`=0, dst ≠ `mac_addr`, and dst ≠ FF:FF:FF:FF:FF:FF.
    6. PAT_ERR: pattern mismatch.
    7. GOOD: none of the above.
  - Exactly one counter increments per frame. RUNT and LONG both increment `cnt_len_err`.
- **WAIT_IDLE**: waits for rxdv=0, then goes to IDLE.
- **Counters**: saturate at all ones and never wrap.
- **Captured fields**: `rx_*` fields hold their values until the next `rx_valid`.

## Timing

- **Reset values**: all outputs 0, state IDLE, registered rxdv 1.
- **Result latency**: the result is registered. `rx_valid` asserts in the cycle after the first rxdv=0 sample; status, fields and counter update appear in that same cycle.
- **PRE_ERR**: `rx_valid` pulses in the cycle after the offending sample.
- **Back-to-back frames**: a 1-cycle rxdv-low gap is sufficient. An rxdv rising edge in the cycle after `rx_valid`, or coincident with it, must be accepted.
- **Reset mid-frame**: discards the frame. No `rx_valid` and no count; the frame's remaining bytes are ignored.

## Test plan

- **Good minimum frame**: preamble 7×0x55 + SFD, dst=`mac_addr`, type 0x002E, 46 pattern bytes 0x01..0x2E, valid FCS -> `rx_valid` pulse, status 0, `rx_len`=64, `rx_eth_type`=0x002E, `cnt_good`=1, `done`=1 with `EXPECT_NUM`=1.
- **Error classes**, on the same frame:
  - last FCS byte XOR 0x01 -> status 5, `cnt_crc_err`=1.
  - `gmii_rxer` high for 1 cycle at byte 20 -> status 2; `cnt_crc_err` unchanged.
  - payload byte 5 changed with FCS recomputed -> status 7.
- **Length and address**:
  - 60-byte frame with valid CRC -> status 3, `cnt_len_err`=1.
  - dst=02:00:00:00:00:09 not matching -> status 6, `cnt_drop`=1.
  - broadcast dst -> status 0.
- **Preamble**:
  - SFD replaced by 0x5D -> status 1, rest of the frame ignored.
  - SFD with no preamble -> status 0.
- **Back-to-back**: three good frames, 1-cycle IFG -> three `rx_valid` pulses, `cnt_good`=3.
- **Reset**:
  - `reset_n` low for 2 cycles at byte 30, then the frame tail continues -> no `rx_valid`, all counters 0.
  - next frame -> status 0.
- **Saturation**: `CNT_W`=2 and 5 CRC-error frames -> `cnt_crc_err`=3.

Source files
------------

// File: rtl/gmii_rx_if.sv
// GMII receive bundle: byte data, data-valid and error strobe on one clock.
interface gmii_rx_if;
    logic [7:0] gmii_rxd;
    logic       gmii_rxdv;
    logic       gmii_rxer;

    modport master (output gmii_rxd, gmii_rxdv, gmii_rxer);
    modport slave  (input  gmii_rxd, gmii_rxdv, gmii_rxer);
endinterface

// File: rtl/gmii_rx_checker.sv
// GMII receive-side frame checker: strips preamble/SFD, checks CRC, length, address and
// payload pattern, reports one result per frame and keeps saturating category counters.
module gmii_rx_checker #(
    parameter int EXPECT_NUM    = 1,
    parameter int PAYLOAD_CHECK = 1,
    parameter int PROMISC       = 0,
    parameter int MAX_FRAME     = 1522,
    parameter int CNT_W         = 16
) (
    input  logic             gmii_rxc,
    input  logic             reset_n,
    gmii_rx_if.slave         gmii,
    input  logic [47:0]      mac_addr,
    output logic             rx_valid,
    output logic [2:0]       rx_status,
    output logic [47:0]      rx_dst_mac,
    output logic [47:0]      rx_src_mac,
    output logic [15:0]      rx_eth_type,
    output logic [15:0]      rx_len,
    output logic [CNT_W-1:0] cnt_good,
    output logic [CNT_W-1:0] cnt_pre_err,
    output logic [CNT_W-1:0] cnt_phy_err,
    output logic [CNT_W-1:0] cnt_len_err,
    output logic [CNT_W-1:0] cnt_crc_err,
    output logic [CNT_W-1:0] cnt_drop,
    output logic [CNT_W-1:0] cnt_pat_err,
    output logic             done
);
    localparam logic [2:0]  ST_GOOD     = 3'd0;
    localparam logic [2:0]  ST_PRE_ERR  = 3'd1;
    localparam logic [2:0]  ST_PHY_ERR  = 3'd2;
    localparam logic [2:0]  ST_RUNT     = 3'd3;
    localparam logic [2:0]  ST_LONG     = 3'd4;
    localparam logic [2:0]  ST_CRC_ERR  = 3'd5;
    localparam logic [2:0]  ST_ADDR     = 3'd6;
    localparam logic [2:0]  ST_PAT_ERR  = 3'd7;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [15:0] MAX_LEN     = 16'(MAX_FRAME);

    typedef enum logic [1:0] {IDLE, PRE, FRAME, WAIT_IDLE} state_t;

    state_t          state;
    logic            rxdv_q;
    logic [2:0]      pre_cnt;
    logic [15:0]     byte_cnt;
    logic [31:0]     crc;
    logic [47:0]     dst_w;
    logic [47:0]     src_w;
    logic [15:0]     type_w;
    logic [3:0][7:0] dly;
    logic [7:0]      pat_exp;
    logic            pat_bad;
    logic            phy_bad;

    logic            pre_act;
    logic            is_pre;
    logic            is_sfd;
    logic            pre_err;
    logic            eof;
    logic [2:0]      eof_status;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // The first byte of a burst is already a preamble candidate, so IDLE shares the PRE decode.
    always_comb begin
        pre_act = (state == PRE) || (state == IDLE && gmii.gmii_rxdv && !rxdv_q);
        is_sfd  = pre_act && gmii.gmii_rxdv && gmii.gmii_rxd == 8'hD5;
        is_pre  = pre_act && gmii.gmii_rxdv && gmii.gmii_rxd == 8'h55 &&
                  (state == IDLE || pre_cnt != 3'd7);
        pre_err = pre_act && !is_sfd && !is_pre;
        eof     = (state == FRAME) && !gmii.gmii_rxdv;

        eof_status = ST_GOOD;
        if (phy_bad)
            eof_status = ST_PHY_ERR;
        else if (byte_cnt < 16'd64)
            eof_status = ST_RUNT;
        else if (byte_cnt > MAX_LEN)
            eof_status = ST_LONG;
        else if (crc != CRC_RESIDUE)
            eof_status = ST_CRC_ERR;
        else if (PROMISC == 0 && dst_w != mac_addr && dst_w != 48'hFFFF_FFFF_FFFF)
            eof_status = ST_ADDR;
        else if (pat_bad)
            eof_status = ST_PAT_ERR;
    end

    always_ff @(posedge gmii_rxc) begin
        if (!reset_n) begin
            state       <= IDLE;
            rxdv_q      <= 1'b1;
            pre_cnt     <= 3'd0;
            byte_cnt    <= 16'd0;
            crc         <= '1;
            dst_w       <= '0;
            src_w       <= '0;
            type_w      <= '0;
            dly         <= '0;
            pat_exp     <= 8'd1;
            pat_bad     <= 1'b0;
            phy_bad     <= 1'b0;
            rx_valid    <= 1'b0;
            rx_status   <= ST_GOOD;
            rx_dst_mac  <= '0;
            rx_src_mac  <= '0;
            rx_eth_type <= '0;
            rx_len      <= '0;
            cnt_good    <= '0;
            cnt_pre_err <= '0;
            cnt_phy_err <= '0;
            cnt_len_err <= '0;
            cnt_crc_err <= '0;
            cnt_drop    <= '0;
            cnt_pat_err <= '0;
            done        <= 1'b0;
        end else begin
            rxdv_q   <= gmii.gmii_rxdv;
            rx_valid <= 1'b0;

            if (is_pre) begin
                state   <= PRE;
                pre_cnt <= (state == IDLE) ? 3'd1 : pre_cnt + 3'd1;
            end

            if (is_sfd) begin
                state    <= FRAME;
                byte_cnt <= 16'd0;
                crc      <= '1;
                dst_w    <= '0;
                src_w    <= '0;
                type_w   <= '0;
                pat_exp  <= 8'd1;
                pat_bad  <= 1'b0;
                phy_bad  <= 1'b0;
            end

            // A bad preamble reports no header; the rest of the burst is skipped in WAIT_IDLE.
            if (pre_err) begin
                state       <= gmii.gmii_rxdv ? WAIT_IDLE : IDLE;
                rx_valid    <= 1'b1;
                rx_status   <= ST_PRE_ERR;
                rx_dst_mac  <= '0;
                rx_src_mac  <= '0;
                rx_eth_type <= '0;
                rx_len      <= '0;
                cnt_pre_err <= sat_inc(cnt_pre_err);
            end

            if (state == FRAME && gmii.gmii_rxdv) begin
                if (byte_cnt <= MAX_LEN)
                    byte_cnt <= byte_cnt + 16'd1;
                crc <= crc_byte(crc, gmii.gmii_rxd);
                if (byte_cnt < 16'd6)
                    dst_w <= {dst_w[39:0], gmii.gmii_rxd};
                else if (byte_cnt < 16'd12)
                    src_w <= {src_w[39:0], gmii.gmii_rxd};
                else if (byte_cnt < 16'd14)
                    type_w <= {type_w[7:0], gmii.gmii_rxd};
                dly <= {dly[2:0], gmii.gmii_rxd};
                // dly[3] is the byte four positions back; from index 18 on it is payload, never FCS.
                if (byte_cnt >= 16'd18) begin
                    if (PAYLOAD_CHECK != 0 && dly[3] != pat_exp)
                        pat_bad <= 1'b1;
                    pat_exp <= pat_exp + 8'd1;
                end
                if (gmii.gmii_rxer)
                    phy_bad <= 1'b1;
            end

            if (eof) begin
                state       <= IDLE;
                rx_valid    <= 1'b1;
                rx_status   <= eof_status;
                rx_dst_mac  <= dst_w;
                rx_src_mac  <= src_w;
                rx_eth_type <= type_w;
                rx_len      <= byte_cnt;
                case (eof_status)
                    ST_GOOD: begin
                        cnt_good <= sat_inc(cnt_good);
                        if (int'(cnt_good) + 1 >= EXPECT_NUM)
                            done <= 1'b1;
                    end
                    ST_PHY_ERR:         cnt_phy_err <= sat_inc(cnt_phy_err);
                    ST_RUNT, ST_LONG:   cnt_len_err <= sat_inc(cnt_len_err);
                    ST_CRC_ERR:         cnt_crc_err <= sat_inc(cnt_crc_err);
                    ST_ADDR:            cnt_drop    <= sat_inc(cnt_drop);
                    default:            cnt_pat_err <= sat_inc(cnt_pat_err);
                endcase
            end

            if (state == WAIT_IDLE && !gmii.gmii_rxdv)
                state <= IDLE;
        end
    end
endmodule

// File: tb/tb_gmii_rx_checker.sv
// Bench for gmii_rx_checker: directed and randomized frames scored against a frame-level
// reference model; a second instance with 2-bit counters covers saturation.
module tb_gmii_rx_checker;
    logic        gmii_rxc = 1'b0;
    logic        reset_n;
    logic [47:0] mac_addr;
    logic [47:0] src_mac;

    logic        rx_valid;
    logic [2:0]  rx_status;
    logic [47:0] rx_dst_mac, rx_src_mac;
    logic [15:0] rx_eth_type, rx_len;
    logic [15:0] cnt_good, cnt_pre_err, cnt_phy_err, cnt_len_err, cnt_crc_err, cnt_drop, cnt_pat_err;
    logic        done;

    logic        s_rx_valid;
    logic [2:0]  s_rx_status;
    logic [47:0] s_rx_dst_mac, s_rx_src_mac;
    logic [15:0] s_rx_eth_type, s_rx_len;
    logic [1:0]  s_cnt_good, s_cnt_pre_err, s_cnt_phy_err, s_cnt_len_err, s_cnt_crc_err, s_cnt_drop, s_cnt_pat_err;
    logic        s_done;

    gmii_rx_if gif ();

    always #5 gmii_rxc = ~gmii_rxc;

    gmii_rx_checker u_dut (
        .gmii_rxc(gmii_rxc), .reset_n(reset_n), .gmii(gif), .mac_addr(mac_addr),
        .rx_valid(rx_valid), .rx_status(rx_status), .rx_dst_mac(rx_dst_mac),
        .rx_src_mac(rx_src_mac), .rx_eth_type(rx_eth_type), .rx_len(rx_len),
        .cnt_good(cnt_good), .cnt_pre_err(cnt_pre_err), .cnt_phy_err(cnt_phy_err),
        .cnt_len_err(cnt_len_err), .cnt_crc_err(cnt_crc_err), .cnt_drop(cnt_drop),
        .cnt_pat_err(cnt_pat_err), .done(done)
    );

    gmii_rx_checker #(.CNT_W(2)) u_sat (
        .gmii_rxc(gmii_rxc), .reset_n(reset_n), .gmii(gif), .mac_addr(mac_addr),
        .rx_valid(s_rx_valid), .rx_status(s_rx_status), .rx_dst_mac(s_rx_dst_mac),
        .rx_src_mac(s_rx_src_mac), .rx_eth_type(s_rx_eth_type), .rx_len(s_rx_len),
        .cnt_good(s_cnt_good), .cnt_pre_err(s_cnt_pre_err), .cnt_phy_err(s_cnt_phy_err),
        .cnt_len_err(s_cnt_len_err), .cnt_crc_err(s_cnt_crc_err), .cnt_drop(s_cnt_drop),
        .cnt_pat_err(s_cnt_pat_err), .done(s_done)
    );

    typedef struct {
        logic [2:0]  st;
        int          cyc;
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] typ;
        logic [15:0] len;
        bit          hdr;
    } res_t;

    res_t       got_q[$];
    res_t       exp_q[$];
    logic [7:0] tx_pre[$];
    logic [7:0] tx_frm[$];
    int         cyc = 0;
    int         n_assert = 0;
    int         n_fail = 0;
    int         m_good, m_pre, m_phy, m_len, m_crc, m_drop, m_pat;

    always @(posedge gmii_rxc) cyc <= cyc + 1;

    always @(negedge gmii_rxc) begin
        if (rx_valid) begin
            res_t r;
            r.st  = rx_status;
            r.cyc = cyc;
            r.dst = rx_dst_mac;
            r.src = rx_src_mac;
            r.typ = rx_eth_type;
            r.len = rx_len;
            r.hdr = 1'b1;
            got_q.push_back(r);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Standard Ethernet FCS over the first n frame bytes.
    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, tx_frm[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic add_fcs(input bit bad);
        logic [31:0] f = fcs_of(tx_frm.size());
        for (int i = 0; i < 4; i++) tx_frm.push_back(f[i*8 +: 8]);
        if (bad) tx_frm[tx_frm.size()-1] ^= 8'h01;
    endtask

    task automatic build(input logic [47:0] d, input int plen, input bit bad_fcs);
        logic [15:0] t = 16'(plen);
        tx_frm.delete();
        for (int i = 5; i >= 0; i--) tx_frm.push_back(d[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) tx_frm.push_back(src_mac[i*8 +: 8]);
        tx_frm.push_back(t[15:8]);
        tx_frm.push_back(t[7:0]);
        for (int k = 0; k < plen; k++) tx_frm.push_back(8'(k + 1));
        add_fcs(bad_fcs);
    endtask

    task automatic corrupt_payload(input int k);
        tx_frm[14+k] ^= 8'hA5;
        repeat (4) void'(tx_frm.pop_back());
        add_fcs(1'b0);
    endtask

    task automatic set_pre(input int n55, input logic [7:0] last);
        tx_pre.delete();
        for (int i = 0; i < n55; i++) tx_pre.push_back(8'h55);
        tx_pre.push_back(last);
    endtask

    // Index of the preamble byte that must be rejected, -1 if the SFD arrives in time.
    function automatic int pre_bad_idx();
        for (int i = 0; i < tx_pre.size(); i++) begin
            if (tx_pre[i] == 8'hD5) return -1;
            if (tx_pre[i] != 8'h55 || i == 7) return i;
        end
        return tx_pre.size();
    endfunction

    function automatic int classify(input bit phy);
        int n = tx_frm.size();
        logic [47:0] d;
        if (phy) return 2;
        if (n < 64) return 3;
        if (n > 1522) return 4;
        if (fcs_of(n - 4) != {tx_frm[n-1], tx_frm[n-2], tx_frm[n-3], tx_frm[n-4]}) return 5;
        d = {tx_frm[0], tx_frm[1], tx_frm[2], tx_frm[3], tx_frm[4], tx_frm[5]};
        if (d != mac_addr && d != 48'hFFFF_FFFF_FFFF) return 6;
        for (int k = 0; 14 + k < n - 4; k++)
            if (tx_frm[14+k] != 8'(k + 1)) return 7;
        return 0;
    endfunction

    task automatic bump(input int st);
        case (st)
            0:       m_good++;
            1:       m_pre++;
            2:       m_phy++;
            3, 4:    m_len++;
            5:       m_crc++;
            6:       m_drop++;
            default: m_pat++;
        endcase
    endtask

    task automatic clear_model();
        m_good = 0; m_pre = 0; m_phy = 0; m_len = 0; m_crc = 0; m_drop = 0; m_pat = 0;
    endtask

    task automatic xmit(input int er_idx, input int rst_idx, input int gap);
        int   bad = pre_bad_idx();
        int   off_cyc = -1;
        int   eof_cyc;
        bit   phy = 1'b0;
        res_t e;
        for (int i = 0; i < tx_pre.size(); i++) begin
            @(negedge gmii_rxc);
            gif.gmii_rxdv = 1'b1; gif.gmii_rxd = tx_pre[i]; gif.gmii_rxer = 1'b0;
            if (i == bad) off_cyc = cyc;
        end
        for (int i = 0; i < tx_frm.size(); i++) begin
            @(negedge gmii_rxc);
            gif.gmii_rxdv = 1'b1; gif.gmii_rxd = tx_frm[i]; gif.gmii_rxer = (i == er_idx);
            if (i == er_idx) phy = 1'b1;
            if (i == rst_idx) reset_n = 1'b0;
            if (i == rst_idx + 2) reset_n = 1'b1;
        end
        @(negedge gmii_rxc);
        gif.gmii_rxdv = 1'b0; gif.gmii_rxd = 8'h00; gif.gmii_rxer = 1'b0;
        eof_cyc = cyc;
        reset_n = 1'b1;
        if (bad == tx_pre.size()) off_cyc = eof_cyc;
        e = '{st: 3'd0, cyc: 0, dst: 48'h0, src: 48'h0, typ: 16'h0, len: 16'h0, hdr: 1'b0};
        if (rst_idx >= 0) begin
            clear_model();
        end else if (bad >= 0) begin
            e.st  = 3'd1;
            e.cyc = off_cyc + 1;
            bump(1);
            exp_q.push_back(e);
        end else begin
            e.st  = 3'(classify(phy));
            e.cyc = eof_cyc + 1;
            e.hdr = 1'b1;
            e.len = 16'(tx_frm.size());
            e.dst = {tx_frm[0], tx_frm[1], tx_frm[2], tx_frm[3], tx_frm[4], tx_frm[5]};
            e.src = {tx_frm[6], tx_frm[7], tx_frm[8], tx_frm[9], tx_frm[10], tx_frm[11]};
            e.typ = {tx_frm[12], tx_frm[13]};
            bump(int'(e.st));
            exp_q.push_back(e);
        end
        repeat (gap - 1) @(negedge gmii_rxc);
    endtask

    function automatic logic [63:0] sat(input int c, input int w);
        int mx = (1 << w) - 1;
        return 64'((c > mx) ? mx : c);
    endfunction

    task automatic chk_cnt(input string tag);
        chk({tag, ".cnt_good"},    64'(cnt_good),    sat(m_good, 16));
        chk({tag, ".cnt_pre_err"}, 64'(cnt_pre_err), sat(m_pre, 16));
        chk({tag, ".cnt_phy_err"}, 64'(cnt_phy_err), sat(m_phy, 16));
        chk({tag, ".cnt_len_err"}, 64'(cnt_len_err), sat(m_len, 16));
        chk({tag, ".cnt_crc_err"}, 64'(cnt_crc_err), sat(m_crc, 16));
        chk({tag, ".cnt_drop"},    64'(cnt_drop),    sat(m_drop, 16));
        chk({tag, ".cnt_pat_err"}, 64'(cnt_pat_err), sat(m_pat, 16));
        chk({tag, ".done"},        64'(done),        64'(m_good >= 1));
        chk({tag, ".sat_crc_err"}, 64'(s_cnt_crc_err), sat(m_crc, 2));
        chk({tag, ".sat_good"},    64'(s_cnt_good),    sat(m_good, 2));
    endtask

    task automatic settle(input string tag);
        int budget = 0;
        repeat (3) @(negedge gmii_rxc);
        while (got_q.size() < exp_q.size() && budget < 50) begin
            @(negedge gmii_rxc);
            budget++;
        end
        chk({tag, ".results"}, 64'(got_q.size()), 64'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            res_t g = got_q.pop_front();
            res_t e = exp_q.pop_front();
            chk({tag, ".status"}, 64'(g.st), 64'(e.st));
            chk({tag, ".latency"}, 64'(g.cyc), 64'(e.cyc));
            if (e.hdr) begin
                chk({tag, ".rx_len"}, 64'(g.len), 64'(e.len));
                chk({tag, ".rx_dst_mac"}, 64'(g.dst), 64'(e.dst));
                chk({tag, ".rx_src_mac"}, 64'(g.src), 64'(e.src));
                chk({tag, ".rx_eth_type"}, 64'(g.typ), 64'(e.typ));
            end
        end
        got_q.delete();
        exp_q.delete();
        chk_cnt(tag);
    endtask

    initial begin
        logic [31:0] r;
        int          kind, plen, er;
        r        = $urandom();
        mac_addr = {16'h0200, r};
        if (mac_addr == 48'h0200_0000_0009) mac_addr[7:0] = 8'h42;
        r        = $urandom();
        src_mac  = {16'h0A0B, r};
        reset_n  = 1'b0;
        gif.gmii_rxd = 8'h00; gif.gmii_rxdv = 1'b0; gif.gmii_rxer = 1'b0;
        clear_model();
        repeat (3) @(negedge gmii_rxc);
        chk("reset.rx_valid", 64'(rx_valid), 64'd0);
        chk("reset.rx_status", 64'(rx_status), 64'd0);
        chk("reset.rx_len", 64'(rx_len), 64'd0);
        chk("reset.rx_dst_mac", 64'(rx_dst_mac), 64'd0);
        chk_cnt("reset");
        reset_n = 1'b1;
        @(negedge gmii_rxc);

        set_pre(7, 8'hD5); build(mac_addr, 46, 1'b0); xmit(-1, -1, 4); settle("good_min");
        build(mac_addr, 46, 1'b1); xmit(-1, -1, 4); settle("crc_err");
        build(mac_addr, 46, 1'b0); xmit(20, -1, 4); settle("phy_err");
        build(mac_addr, 46, 1'b0); corrupt_payload(5); xmit(-1, -1, 4); settle("pat_err");
        build(mac_addr, 42, 1'b0); xmit(-1, -1, 4); settle("runt");
        build(48'h0200_0000_0009, 46, 1'b0); xmit(-1, -1, 4); settle("addr_drop");
        build(48'hFFFF_FFFF_FFFF, 46, 1'b0); xmit(-1, -1, 4); settle("broadcast");

        set_pre(7, 8'h5D); build(mac_addr, 46, 1'b0); xmit(-1, -1, 4); settle("bad_sfd");
        set_pre(8, 8'hD5); build(mac_addr, 46, 1'b0); xmit(-1, -1, 4); settle("long_pre");
        set_pre(2, 8'h55); tx_frm.delete(); xmit(-1, -1, 4); settle("pre_cut");
        set_pre(0, 8'hD5); build(mac_addr, 46, 1'b0); xmit(-1, -1, 4); settle("sfd_only");

        for (int i = 0; i < 3; i++) begin
            set_pre($urandom_range(0, 7), 8'hD5);
            build(mac_addr, $urandom_range(46, 120), 1'b0);
            xmit(-1, -1, 1);
        end
        settle("back_to_back");

        set_pre(7, 8'hD5); build(mac_addr, 46, 1'b0); xmit(-1, 30, 4); settle("reset_mid");
        build(mac_addr, 46, 1'b0); xmit(-1, -1, 4); settle("after_reset");

        for (int i = 0; i < 5; i++) begin
            build(mac_addr, 46, 1'b1);
            xmit(-1, -1, 2);
        end
        settle("crc_sat");

        for (int i = 0; i < 10; i++) begin
            kind = $urandom_range(0, 6);
            plen = $urandom_range(46, 100);
            er   = -1;
            set_pre($urandom_range(0, 7), 8'hD5);
            case (kind)
                1: build(mac_addr, plen, 1'b1);
                2: begin build(mac_addr, plen, 1'b0); corrupt_payload($urandom_range(0, plen - 1)); end
                3: build(48'h0200_0000_0009, plen, 1'b0);
                4: build(mac_addr, $urandom_range(20, 45), 1'b0);
                5: begin build(mac_addr, plen, 1'b0); er = $urandom_range(0, plen + 17); end
                6: build(48'hFFFF_FFFF_FFFF, plen, 1'b0);
                default: build(mac_addr, plen, 1'b0);
            endcase
            xmit(er, -1, $urandom_range(1, 3));
        end
        settle("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
